// File: rtl/data_ram_slave.sv
// Wait-state data RAM slave for the memory stage: latches a request, stalls the
// pipeline for WAIT_CYCLES, then performs one byte-lane masked access.
// Optional macro DATA_RAM_BOUND_CHECK_EN flags addresses beyond the array with err_o.
module data_ram_slave #(
    parameter int DATA_MEM_NUM_LOG2 = 10,
    parameter int WAIT_CYCLES       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << DATA_MEM_NUM_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;
    logic        w_access;

    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_data;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [0:DEPTH-1];

    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [3:0]  w_acc_sel;
    logic [31:0] w_acc_data;
    logic [DATA_MEM_NUM_LOG2-1:0] w_idx;
    logic        w_oob;
    logic        w_unused_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (ce) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = DONE;
                        w_access    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!ce) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = DONE;
                    w_access    = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // With zero wait states the access happens on the latching edge itself, so
    // the request registers are bypassed by the values being latched.
    assign w_acc_we   = w_latch ? we     : r_we;
    assign w_acc_addr = w_latch ? addr   : r_addr;
    assign w_acc_sel  = w_latch ? sel    : r_sel;
    assign w_acc_data = w_latch ? data_i : r_data;
    assign w_idx      = w_acc_addr[DATA_MEM_NUM_LOG2+1:2];

`ifdef DATA_RAM_BOUND_CHECK_EN
    logic r_err;

    assign w_oob         = |w_acc_addr[31:DATA_MEM_NUM_LOG2+2];
    assign w_unused_addr = ^w_acc_addr[1:0];
    assign err_o         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_access & w_oob;
        end
    end
`else
    assign w_oob         = 1'b0;
    assign w_unused_addr = ^{w_acc_addr[31:DATA_MEM_NUM_LOG2+2], w_acc_addr[1:0]};
    assign err_o         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_sel   <= 4'd0;
            r_data  <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_we   <= we;
                r_addr <= addr;
                r_sel  <= sel;
                r_data <= data_i;
            end
            if (w_access && !w_acc_we && !w_oob) begin
                r_rdata <= r_mem[w_idx];
            end else begin
                r_rdata <= 32'd0;
            end
        end
    end

    // The array itself is never reset; a reset edge simply suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_acc_we && !w_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_acc_data[8*b +: 8];
                end
            end
        end
    end

    assign data_o     = r_rdata;
    assign ack_o      = (r_state == DONE);
    assign stallreq_o = ce & (r_state != DONE) & ~rst;

endmodule

// File: tb/tb_data_ram_slave.sv
// Scoreboard bench for data_ram_slave: directed accesses push expected {err,data}
// into a queue that a negedge monitor pops on every ack_o pulse.
module tb_data_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, ce0, ce15;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] dataIn;

    logic [31:0] dataOut, dataOut0, dataOut15;
    logic        stall, stall0, stall15;
    logic        ack, ack0, ack15;
    logic        err, err0, err15;

    logic [32:0] expQ [$];
    int          vecCount = 0;
    int          errCount = 0;
    bit          monitorOn = 1'b0;

    always #5 clk = ~clk;

    data_ram_slave #(.DATA_MEM_NUM_LOG2(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(dataIn), .data_o(dataOut), .stallreq_o(stall), .ack_o(ack), .err_o(err)
    );

    data_ram_slave #(.DATA_MEM_NUM_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we), .addr(addr), .sel(sel),
        .data_i(dataIn), .data_o(dataOut0), .stallreq_o(stall0), .ack_o(ack0), .err_o(err0)
    );

    data_ram_slave #(.DATA_MEM_NUM_LOG2(10), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .ce(ce15), .we(we), .addr(addr), .sel(sel),
        .data_i(dataIn), .data_o(dataOut15), .stallreq_o(stall15), .ack_o(ack15), .err_o(err15)
    );

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every ack must match the oldest outstanding expectation; outside ack the
    // read bus and error flag must stay at zero.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (ack) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedAck", {32'd0, ack}, 33'd0);
                end else begin
                    checkOutput("response", {err, dataOut}, expQ.pop_front());
                end
            end else begin
                checkOutput("idleBus", {err, dataOut}, 33'd0);
            end
        end
    end

    // Issues one access on the W=2 instance, called just after a rising edge.
    // Leaves ce high; the caller follows with another access or idleCycles.
    task automatic applyStimulus(input logic weV, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input logic [32:0] exp);
        int cyc;
        int stalls;
        bit done;
        expQ.push_back(exp);
        ce = 1'b1; we = weV; addr = a; sel = s; dataIn = d;
        cyc = 0; stalls = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (stall) stalls++;
            if (ack) done = 1'b1;
            else cyc++;
        end
        checkOutput("ackCycle", 33'(cyc), 33'd3);
        checkOutput("stallCycles", 33'(stalls), 33'd3);
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        ce = 1'b0; we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sweepAccess(input int which, input logic weV, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] expData, input int expLat);
        int cyc;
        int stalls;
        bit done;
        logic st, ak;
        logic [31:0] dv;
        we = weV; addr = a; sel = 4'hF; dataIn = d;
        if (which == 0) ce0 = 1'b1; else ce15 = 1'b1;
        cyc = 0; stalls = 0; done = 1'b0; dv = 32'd0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            st = (which == 0) ? stall0 : stall15;
            ak = (which == 0) ? ack0 : ack15;
            if (st) stalls++;
            if (ak) begin
                done = 1'b1;
                dv = (which == 0) ? dataOut0 : dataOut15;
            end else begin
                cyc++;
            end
        end
        checkOutput("sweepAckCycle", 33'(cyc), 33'(expLat));
        checkOutput("sweepStalls", 33'(stalls), 33'(expLat));
        checkOutput("sweepData", {1'b0, dv}, {1'b0, expData});
        @(posedge clk); #1;
        ce0 = 1'b0; ce15 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; ce0 = 1'b0; ce15 = 1'b0;
        we = 1'b0; addr = 32'd0; sel = 4'd0; dataIn = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetStall", {32'd0, stall}, 33'd0);
        checkOutput("resetAck", {32'd0, ack}, 33'd0);
        checkOutput("resetData", {err, dataOut}, 33'd0);
        @(posedge clk); #1;
        rst = 1'b0; ce = 1'b0;
        monitorOn = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 32'h10, 4'hF, 32'h12345678, 33'd0);
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, {1'b0, 32'h12345678});
        applyStimulus(1'b1, 32'h11, 4'h4, 32'hAAAAAAAA, 33'd0);
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, {1'b0, 32'h12AA5678});
        applyStimulus(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 33'd0);
        applyStimulus(1'b0, 32'h13, 4'h1, 32'h0, {1'b0, 32'h12AA5678});
        idleCycles(2);

        // Flush: drop ce during the first wait cycle of a write.
        applyStimulus(1'b1, 32'h20, 4'hF, 32'h0BADF00D, 33'd0);
        idleCycles(1);
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; dataIn = 32'hDEADBEEF;
        @(posedge clk); #1;
        ce = 1'b0;
        idleCycles(3);
        applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, {1'b0, 32'h0BADF00D});
        idleCycles(1);

        // Reset arriving while a write is waiting.
        applyStimulus(1'b1, 32'h40, 4'hF, 32'h11112222, 33'd0);
        idleCycles(1);
        ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; dataIn = 32'h99999999;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("stallDuringReset", {32'd0, stall}, 33'd0);
        @(posedge clk); #1;
        rst = 1'b0; ce = 1'b0;
        @(negedge clk);
        checkOutput("ackAfterReset", {32'd0, ack}, 33'd0);
        idleCycles(2);
        applyStimulus(1'b0, 32'h40, 4'hF, 32'h0, {1'b0, 32'h11112222});
        idleCycles(1);

        // Address just past the array.
        applyStimulus(1'b1, 32'h0, 4'hF, 32'hCAFE0001, 33'd0);
`ifdef DATA_RAM_BOUND_CHECK_EN
        applyStimulus(1'b1, 32'h1000, 4'hF, 32'h5555AAAA, {1'b1, 32'h0});
        applyStimulus(1'b0, 32'h1000, 4'hF, 32'h0, {1'b1, 32'h0});
        applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, {1'b0, 32'hCAFE0001});
`else
        applyStimulus(1'b1, 32'h1000, 4'hF, 32'h5555AAAA, 33'd0);
        applyStimulus(1'b0, 32'h1000, 4'hF, 32'h0, {1'b0, 32'h5555AAAA});
        applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, {1'b0, 32'h5555AAAA});
`endif

        // Back-to-back with ce held high between accesses.
        applyStimulus(1'b1, 32'h80, 4'hF, 32'hA5A5A5A5, 33'd0);
        applyStimulus(1'b0, 32'h80, 4'hF, 32'h0, {1'b0, 32'hA5A5A5A5});
        applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, {1'b0, 32'h12AA5678});
        applyStimulus(1'b1, 32'h84, 4'hF, 32'h11223344, 33'd0);
        applyStimulus(1'b0, 32'h84, 4'hF, 32'h0, {1'b0, 32'h11223344});
        idleCycles(2);

        sweepAccess(0, 1'b1, 32'h8, 32'h77777777, 32'h0, 1);
        sweepAccess(0, 1'b0, 32'h8, 32'h0, 32'h77777777, 1);
        sweepAccess(1, 1'b1, 32'h8, 32'h66665555, 32'h0, 16);
        sweepAccess(1, 1'b0, 32'h8, 32'h0, 32'h66665555, 16);

        idleCycles(3);
        checkOutput("queueDrained", 33'(expQ.size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/data_ram_slave.md
DATA_RAM_SLAVE -- requirements
Module: data_ram_slave

Interface
REQ-001 SHALL have parameter DATA_MEM_NUM_LOG2, default 10, giving log2 of the word count (1024 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted before completion (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ce, input, 1 bit: access request (chip enable) from the memory stage.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port sel, input, 4 bits: byte-lane select, where sel[3] maps to data[31:24] and sel[0] maps to data[7:0].
REQ-009 SHALL have port data_i, input, 32 bits: write data.
REQ-010 SHALL have port data_o, output, 32 bits: read data.
REQ-011 SHALL have port stallreq_o, output, 1 bit: pipeline stall request.
REQ-012 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err_o, output, 1 bit: one-cycle error pulse (see Configuration).

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, WAIT and DONE; a counter cnt[3:0]; and request registers for we, addr, sel and data_i.
REQ-015 In IDLE with ce=1, the FSM SHALL latch the request; it SHALL then go to DONE if WAIT_CYCLES=0, otherwise to WAIT with cnt=WAIT_CYCLES-1.
REQ-016 In IDLE with ce=0, the FSM SHALL stay in IDLE.
REQ-017 In WAIT with ce=1, the FSM SHALL decrement cnt while cnt!=0, and go to DONE when cnt=0.
REQ-018 In WAIT with ce=0 (flush), the FSM SHALL return to IDLE, perform no array write and raise no ack_o.
REQ-019 The array access SHALL occur on the clock edge entering DONE and SHALL use only the latched request; input changes after latching SHALL be ignored.
REQ-020 On a write, the block SHALL update only the bytes whose sel bit is 1; sel=0000 SHALL leave memory unchanged but still complete with ack_o.
REQ-021 On a read, data_o SHALL carry the full 32-bit word regardless of sel; byte extraction is the requester's job.
REQ-022 The word index SHALL be addr[DATA_MEM_NUM_LOG2+1:2]; addr[1:0] SHALL be ignored by the array.
REQ-023 data_o SHALL be valid only in DONE, and SHALL be 0 in all other states and in DONE for a write.
REQ-024 In DONE, ack_o SHALL be 1 for exactly one cycle and the next state SHALL be IDLE unconditionally.
REQ-025 stallreq_o SHALL equal ce AND (state != DONE), combinationally.
REQ-026 Consequently a request at cycle 0 SHALL be stalled for cycles 0..WAIT_CYCLES and SHALL complete at cycle WAIT_CYCLES+1.
REQ-027 For back-to-back requests, ce held at 1 after DONE SHALL start a new access from IDLE on the following cycle, with no lost or duplicated access.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set state=IDLE and cnt=0, clear the request registers, and set data_o=0, ack_o=0 and err_o=0.
REQ-029 stallreq_o SHALL be forced to 0 while rst=1.
REQ-030 A reset asserted in WAIT SHALL abort the access with no array write.
REQ-031 Memory array contents SHALL NOT be reset.

Configuration
REQ-032 Macro DATA_RAM_BOUND_CHECK_EN SHALL control out-of-range address handling.
REQ-033 With DATA_RAM_BOUND_CHECK_EN defined, a latched access with any nonzero bit in addr[31:DATA_MEM_NUM_LOG2+2] SHALL perform no write, give data_o=0, and assert err_o and ack_o together for the single DONE cycle.
REQ-034 Without DATA_RAM_BOUND_CHECK_EN, err_o SHALL be tied to 0 and the upper address bits SHALL be ignored, so addresses wrap modulo 4*2^DATA_MEM_NUM_LOG2 bytes.

Verification
REQ-035 Word write then read: write addr=0x00000010, sel=1111, data_i=0x12345678, then read the same address -> stallreq_o high for 3 cycles each access, ack_o pulses at cycle 3, read data_o=0x12345678.
REQ-036 Byte lanes: after REQ-035, write sel=0100, data_i=0xAAAAAAAA to 0x00000011, then read 0x00000010 -> data_o=0x12AA5678.
REQ-037 Flush: start write 0xDEADBEEF to 0x20, drop ce in the first WAIT cycle, then read 0x20 -> no ack_o on the aborted write, and the old contents are returned.
REQ-038 Reset mid-access: assert rst in WAIT -> next cycle state=IDLE with all outputs 0 and no write; a subsequent read returns the prior data.
REQ-039 Bound check: access addr=0x00001000 (default parameters) -> with the macro defined, err_o=1, ack_o=1 and data_o=0 with word 0 unchanged; without the macro, the access aliases to word 0.
REQ-040 Latency sweep: WAIT_CYCLES=0 gives ack_o at cycle 1 with stallreq_o high for 1 cycle; WAIT_CYCLES=15 gives ack_o at cycle 16.
